// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sha256_pkg
// Description : Shared widths, limits and feeder state encoding for the
//               SHA-256 message feeder and its digest serializer.
// Revision    : 1.0 - initial release
// ============================================================================
package sha256_pkg;

  // Largest accepted message length in bytes (1 GiB).
  localparam logic [31:0] MAX_BYTES    = 32'h4000_0000;
  localparam int          HASH_W       = 256;
  localparam int          WORD_W       = 32;
  localparam int          DIGEST_WORDS = 8;

  // Feeder state encoding.
  localparam logic [2:0] C_ST_IDLE      = 3'd0;
  localparam logic [2:0] C_ST_KICK      = 3'd1;
  localparam logic [2:0] C_ST_PACK      = 3'd2;
  localparam logic [2:0] C_ST_SEND      = 3'd3;
  localparam logic [2:0] C_ST_WAIT_DONE = 3'd4;
  localparam logic [2:0] C_ST_DIGEST    = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE      = C_ST_IDLE,
    ST_KICK      = C_ST_KICK,
    ST_PACK      = C_ST_PACK,
    ST_SEND      = C_ST_SEND,
    ST_WAIT_DONE = C_ST_WAIT_DONE,
    ST_DIGEST    = C_ST_DIGEST
  } feeder_state_t;

endpackage
`default_nettype wire

// File: rtl/sha256_msg_feeder_if.sv
`default_nettype none
// ============================================================================
// Interface   : sha256_msg_feeder_if
// Description : Command, byte-stream, processor and digest signals of the
//               SHA-256 message feeder.
//               master : the feeder (drives busy/err, byte_ready, sha_*, dig_*)
//               slave  : its environment (command source, byte FIFO,
//                        hash processor, digest consumer)
// Revision    : 1.0 - initial release
// ============================================================================
interface sha256_msg_feeder_if;
  import sha256_pkg::*;

  logic                cmd_start;
  logic [31:0]         cmd_len;
  logic                cmd_busy;
  logic                err;
  logic [7:0]          byte_data;
  logic                byte_valid;
  logic                byte_ready;
  logic                sha_start;
  logic [WORD_W-1:0]   sha_data;
  logic                sha_valid;
  logic                sha_last;
  logic                sha_ready;
  logic                sha_done;
  logic [HASH_W-1:0]   sha_hash;
  logic [WORD_W-1:0]   dig_word;
  logic                dig_valid;
  logic                dig_last;
  logic                dig_ready;

  modport master (
    input  cmd_start, cmd_len, byte_data, byte_valid,
           sha_ready, sha_done, sha_hash, dig_ready,
    output cmd_busy, err, byte_ready, sha_start, sha_data, sha_valid,
           sha_last, dig_word, dig_valid, dig_last
  );

  modport slave (
    output cmd_start, cmd_len, byte_data, byte_valid,
           sha_ready, sha_done, sha_hash, dig_ready,
    input  cmd_busy, err, byte_ready, sha_start, sha_data, sha_valid,
           sha_last, dig_word, dig_valid, dig_last
  );

endinterface
`default_nettype wire

// File: rtl/sha256_digest_serializer.sv
`default_nettype none
// ============================================================================
// Module      : sha256_digest_serializer
// Description : Loads a 256-bit digest and shifts it out as 8 big-endian
//               32-bit words over valid/ready, word 0 = hash[255:224].
// Ports       : clk, rst     clock, synchronous active-high reset
//               i_load       capture i_hash and start presenting word 0
//               i_hash       digest to serialize
//               i_ready      downstream accepts o_word
//               o_word       current digest word (0 when idle)
//               o_valid      o_word valid, held until i_ready
//               o_last       high with the final word
//               o_done       final word transferred this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_digest_serializer
  import sha256_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [HASH_W-1:0] i_hash,
  input  logic              i_ready,
  output logic [WORD_W-1:0] o_word,
  output logic              o_valid,
  output logic              o_last,
  output logic              o_done
);

  localparam int                 C_CNT_W    = $clog2(DIGEST_WORDS);
  localparam logic [C_CNT_W-1:0] C_LAST_IDX = C_CNT_W'(DIGEST_WORDS - 1);

  logic [HASH_W-1:0]  r_shift;
  logic [C_CNT_W-1:0] r_cnt;
  logic               r_valid;
  logic               w_fire;

  assign w_fire = r_valid & i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_shift <= i_hash;
      r_cnt   <= '0;
      r_valid <= 1'b1;
    end else if (w_fire) begin
      if (r_cnt == C_LAST_IDX) begin
        // Clear so the word output returns to 0 once the digest is gone.
        r_shift <= '0;
        r_cnt   <= '0;
        r_valid <= 1'b0;
      end else begin
        r_shift <= r_shift << WORD_W;
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end

  assign o_word  = r_shift[HASH_W-1 -: WORD_W];
  assign o_valid = r_valid;
  assign o_last  = r_valid && (r_cnt == C_LAST_IDX);
  assign o_done  = w_fire && (r_cnt == C_LAST_IDX);

endmodule
`default_nettype wire

// File: rtl/sha256_msg_feeder.sv
`default_nettype none
// ============================================================================
// Module      : sha256_msg_feeder
// Description : Packs a byte stream into big-endian 32-bit words for a
//               SHA-256 processor, kicks it with sha_start, waits for
//               sha_done (with timeout) and returns the digest as 8 words.
// Ports       : clk, rst     clock, synchronous active-high reset
//               bus          sha256_msg_feeder_if.master: command
//                            (cmd_start/cmd_len/cmd_busy/err), byte stream
//                            (byte_*), processor (sha_*), digest (dig_*)
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_msg_feeder #(
  parameter logic [31:0] MAX_BYTES      = sha256_pkg::MAX_BYTES,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd65535
) (
  input  logic                clk,
  input  logic                rst,
  sha256_msg_feeder_if.master bus
);
  import sha256_pkg::*;

  feeder_state_t     r_state, w_next;
  logic [31:0]       r_remaining, w_rem_nxt;
  logic [31:0]       r_timer, w_timer_nxt;
  logic [1:0]        r_idx;
  logic [WORD_W-1:0] r_word, w_lane_word;
  logic              r_busy, r_err, r_sha_start, r_byte_ready;
  logic              r_sha_valid, r_sha_last;
  logic              w_len_ok, w_accept, w_sha_fire, w_timeout;
  logic              w_dig_load, w_dig_done;

  assign w_len_ok    = (bus.cmd_len != 32'd0) && (bus.cmd_len <= MAX_BYTES);
  // r_byte_ready is only ever high in PACK, so it doubles as the state qualifier.
  assign w_accept    = r_byte_ready & bus.byte_valid;
  assign w_sha_fire  = r_sha_valid & bus.sha_ready;
  assign w_rem_nxt   = w_accept ? (r_remaining - 32'd1) : r_remaining;
  assign w_timer_nxt = (r_timer == 32'hFFFF_FFFF) ? r_timer : (r_timer + 32'd1);
  assign w_timeout   = (w_timer_nxt >= TIMEOUT_CYCLES);
  assign w_dig_load  = (r_state == ST_WAIT_DONE) && bus.sha_done;

  // Current word with the incoming byte dropped into lane r_idx (lane 0 = MSB).
  always_comb begin
    w_lane_word = r_word;
    case (r_idx)
      2'd0:    w_lane_word[31:24] = bus.byte_data;
      2'd1:    w_lane_word[23:16] = bus.byte_data;
      2'd2:    w_lane_word[15:8]  = bus.byte_data;
      default: w_lane_word[7:0]   = bus.byte_data;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (bus.cmd_start && w_len_ok) w_next = ST_KICK;
      ST_KICK:      w_next = ST_PACK;
      ST_PACK:      if (w_accept && ((r_idx == 2'd3) || (r_remaining == 32'd1)))
                      w_next = ST_SEND;
      ST_SEND:      if (w_sha_fire) w_next = r_sha_last ? ST_WAIT_DONE : ST_PACK;
      ST_WAIT_DONE: if (bus.sha_done)   w_next = ST_DIGEST;
                    else if (w_timeout) w_next = ST_IDLE;
      ST_DIGEST:    if (w_dig_done) w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_remaining  <= '0;
      r_idx        <= '0;
      r_word       <= '0;
      r_timer      <= '0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
      r_sha_start  <= 1'b0;
      r_byte_ready <= 1'b0;
      r_sha_valid  <= 1'b0;
      r_sha_last   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.cmd_start) begin
            if (w_len_ok) begin
              r_remaining <= bus.cmd_len;
              r_idx       <= '0;
              r_word      <= '0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_PACK: begin
          if (w_accept) begin
            r_word      <= w_lane_word;
            r_remaining <= w_rem_nxt;
            r_idx       <= r_idx + 2'd1;
          end
        end
        ST_SEND: begin
          // Start the next word from zero so a short final word has zero tail lanes.
          if (w_sha_fire) r_word <= '0;
        end
        ST_WAIT_DONE: begin
          if (!bus.sha_done && w_timeout) r_err <= 1'b1;
        end
        default: ;
      endcase

      // Counts only while waiting; any other state rearms it from zero.
      r_timer      <= (r_state == ST_WAIT_DONE) ? w_timer_nxt : 32'd0;

      // Control outputs are registered from the next state.
      r_busy       <= (w_next != ST_IDLE);
      r_sha_start  <= (w_next == ST_KICK);
      r_byte_ready <= (w_next == ST_PACK);
      r_sha_valid  <= (w_next == ST_SEND);
      r_sha_last   <= (w_next == ST_SEND) && (w_rem_nxt == 32'd0);
    end
  end

  sha256_digest_serializer u_digest (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_dig_load),
    .i_hash  (bus.sha_hash),
    .i_ready (bus.dig_ready),
    .o_word  (bus.dig_word),
    .o_valid (bus.dig_valid),
    .o_last  (bus.dig_last),
    .o_done  (w_dig_done)
  );

  assign bus.cmd_busy   = r_busy;
  assign bus.err        = r_err;
  assign bus.byte_ready = r_byte_ready;
  assign bus.sha_start  = r_sha_start;
  assign bus.sha_data   = r_word;
  assign bus.sha_valid  = r_sha_valid;
  assign bus.sha_last   = r_sha_last;

endmodule
`default_nettype wire
